pipelined_cla_adder: RTL

//  Parametrised, pipelined carry-lookahead adder/subtractor; successor to our 4-bit CLA.

---
 rtl/pipelined_cla_adder_if.sv | 27 ++
 rtl/pipelined_cla_adder.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder_if.sv
// Valid/ready stream bundle for the pipelined CLA adder/subtractor.
// The master side drives operands and out_ready; the slave side is the adder.
interface pipelined_cla_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Ovf;

    modport master (
        output in_valid, A, B, Cin, sub, out_ready,
        input  in_ready, out_valid, Sum, Cout, Ovf
    );

    modport slave (
        input  in_valid, A, B, Cin, sub, out_ready,
        output in_ready, out_valid, Sum, Cout, Ovf
    );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: each stage resolves one GROUP-bit
// lookahead group, so timing depends on GROUP only. Streams under valid/ready.
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipelined_cla_adder_if.slave io
);
    localparam int GDIV = (GROUP < 1) ? 1 : GROUP;
    localparam int NSTG = WIDTH / GDIV;

    generate
        if ((GROUP < 1) || ((WIDTH % GDIV) != 0)) begin : g_bad_cfg
            $error("pipelined_cla_adder: WIDTH must be a positive multiple of GROUP");
        end
    endgenerate

    // Flat sum-of-products carries for one group; no carry ripples between bits.
    function automatic logic [GROUP:0] cla_carries(
        input logic [GROUP-1:0] g,
        input logic [GROUP-1:0] p,
        input logic             cin
    );
        logic [GROUP:0] c;
        logic           term;
        logic           prop;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < GROUP; i++) begin
            term = g[i];
            prop = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                term = term | (prop & g[j]);
                prop = prop & p[j];
            end
            c[i+1] = term | (prop & cin);
        end
        return c;
    endfunction

    logic                        advance_s;
    logic [NSTG-1:0]             vld_q;
    logic [NSTG-1:0][WIDTH-1:0]  a_q;
    logic [NSTG-1:0][WIDTH-1:0]  b_q;
    logic [NSTG-1:0][WIDTH-1:0]  s_q;
    logic [NSTG-1:0]             c_q;
    logic                        ovf_q;

    logic [NSTG-1:0]             src_v_s;
    logic [NSTG-1:0][WIDTH-1:0]  src_a_s;
    logic [NSTG-1:0][WIDTH-1:0]  src_b_s;
    logic [NSTG-1:0][WIDTH-1:0]  src_s_s;
    logic [NSTG-1:0]             src_c_s;

    logic [NSTG-1:0][WIDTH-1:0]  s_d;
    logic [NSTG-1:0]             c_d;
    logic [NSTG-1:0]             cmsb_d;
    logic                        unused_s;

    assign advance_s    = !vld_q[NSTG-1] || io.out_ready;
    assign io.in_ready  = advance_s;
    assign io.out_valid = vld_q[NSTG-1];
    assign io.Sum       = s_q[NSTG-1];
    assign io.Cout      = c_q[NSTG-1];
    assign io.Ovf       = ovf_q;

    // Operands already consumed by earlier stages are dropped by synthesis.
    assign unused_s = ^{a_q[NSTG-1], b_q[NSTG-1], cmsb_d, src_a_s, src_b_s};

    // Per-stage operand sources: stage 0 from the bus, stage k from register k-1.
    always_comb begin
        src_v_s    = '0;
        src_a_s    = '0;
        src_b_s    = '0;
        src_s_s    = '0;
        src_c_s    = '0;
        src_v_s[0] = io.in_valid;
        src_a_s[0] = io.A;
        src_b_s[0] = io.sub ? ~io.B : io.B;
        src_c_s[0] = io.sub ? 1'b1 : io.Cin;
        for (int k = 1; k < NSTG; k++) begin
            src_v_s[k] = vld_q[k-1];
            src_a_s[k] = a_q[k-1];
            src_b_s[k] = b_q[k-1];
            src_s_s[k] = s_q[k-1];
            src_c_s[k] = c_q[k-1];
        end
    end

    // Stage k resolves group k and merges it into the partially built sum.
    always_comb begin
        logic [GROUP-1:0] g_v;
        logic [GROUP-1:0] p_v;
        logic [GROUP:0]   cv_v;
        g_v    = '0;
        p_v    = '0;
        cv_v   = '0;
        s_d    = src_s_s;
        c_d    = '0;
        cmsb_d = '0;
        for (int k = 0; k < NSTG; k++) begin
            g_v  = src_a_s[k][k*GROUP +: GROUP] & src_b_s[k][k*GROUP +: GROUP];
            p_v  = src_a_s[k][k*GROUP +: GROUP] ^ src_b_s[k][k*GROUP +: GROUP];
            cv_v = cla_carries(g_v, p_v, src_c_s[k]);
            s_d[k][k*GROUP +: GROUP] = p_v ^ cv_v[GROUP-1:0];
            c_d[k]    = cv_v[GROUP];
            cmsb_d[k] = cv_v[GROUP-1];
        end
    end

    // Pipeline registers: shift together on advance; bubbles leave data untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
        end else if (advance_s) begin
            vld_q <= src_v_s;
            for (int k = 0; k < NSTG; k++) begin
                if (src_v_s[k]) begin
                    a_q[k] <= src_a_s[k];
                    b_q[k] <= src_b_s[k];
                    s_q[k] <= s_d[k];
                    c_q[k] <= c_d[k];
                end
            end
            if (src_v_s[NSTG-1]) begin
                ovf_q <= cmsb_d[NSTG-1] ^ c_d[NSTG-1];
            end
        end
    end
endmodule
